// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock divider: output mode encodings
// and the power-on divisor.
package clkdiv_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int CLKDIV_DEF_DIV = 32'd50000000;

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: counter, terminal-count strobe, toggle/pulse output and
// a pending-divisor slot that is only committed at a safe point in the period.
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             tc_s;

  assign tc_s = (cnt_q == div_act_q);

  always_comb begin
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;

    if (wr) begin
      div_pend_d = wr_val;
      pend_d     = 1'b1;
    end else begin
      div_pend_d = div_pend_q;
    end

    if (sync) begin
      // A write in the same cycle as sync wins over an older pending value.
      cnt_d     = {CNT_W{1'b0}};
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      pend_d    = 1'b0;
      if (wr) begin
        div_act_d = wr_val;
      end else if (pend_q) begin
        div_act_d = div_pend_q;
      end else begin
        div_act_d = div_act_q;
      end
    end else if (!en) begin
      cnt_d     = {CNT_W{1'b0}};
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      if (pend_q) begin
        div_act_d = div_pend_q;
        pend_d    = wr;
      end else begin
        div_act_d = div_act_q;
      end
    end else if (tc_s) begin
      cnt_d  = {CNT_W{1'b0}};
      tick_d = 1'b1;
      if (mode == MODE_PULSE) begin
        clk_out_d = 1'b1;
      end else begin
        clk_out_d = ~clk_out_q;
      end
      // Retune only here so the period in flight always finishes on the old divisor.
      if (pend_q) begin
        div_act_d = div_pend_q;
        pend_d    = wr;
      end else begin
        div_act_d = div_act_q;
      end
    end else begin
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      tick_d = 1'b0;
      if (mode == MODE_PULSE) begin
        clk_out_d = 1'b0;
      end else begin
        clk_out_d = clk_out_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {CNT_W{1'b0}};
      div_act_q  <= DEF_DIV_C;
      div_pend_q <= DEF_DIV_C;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_clkdiv.sv
// Multi-channel programmable clock divider: decodes divisor writes to one
// channel and fans the shared sync strobe out to all of them.
module prog_clkdiv
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = CLKDIV_DEF_DIV,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr_ch_s;

  // Selects that do not match any channel index fall through with no write.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch_s[i] = div_wr && (div_sel == SEL_W'(i));

    clkdiv_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .mode    (mode[i]),
      .sync    (sync),
      .wr      (wr_ch_s[i]),
      .wr_val  (div_val),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_clkdiv.sv
// Directed bench for prog_clkdiv with two 4-bit channels and a reset divisor of 3.
module tb_prog_clkdiv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] mode;
  logic       sync;
  logic       div_wr;
  logic [0:0] div_sel;
  logic [3:0] div_val;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int n_chk  = 0;
  int n_fail = 0;

  prog_clkdiv #(
    .NUM_CH  (2),
    .CNT_W   (4),
    .DEF_DIV (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .sync    (sync),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tk_tab [4];
  logic [1:0] ck_tab [4];

  initial begin
    tk_tab = '{2'b00, 2'b01, 2'b00, 2'b11};
    ck_tab = '{2'b00, 2'b01, 2'b01, 2'b10};

    rst_n = 1'b0; en = 2'b11; mode = 2'b00; sync = 1'b0;
    div_wr = 1'b0; div_sel = 1'b0; div_val = 4'd0;
    #3;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_clk", 32'(clk_out), 32'd0);
    step();
    check("rst_hold_tick", 32'(tick), 32'd0);
    check("rst_hold_clk", 32'(clk_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both channels on the reset divisor: tick every 4, output period 8.
    for (int k = 1; k <= 16; k++) begin
      step();
      check("base_tick", 32'(tick), (k % 4 == 0) ? 32'd3 : 32'd0);
      check("base_clk", 32'(clk_out), ((k / 4) % 2 == 1) ? 32'd3 : 32'd0);
    end

    // Retune channel 0 to 1 mid-period; the current period of 4 must finish first.
    step();
    check("pre_wr_tick", 32'(tick), 32'd0);
    step();
    check("pre_wr_tick", 32'(tick), 32'd0);
    div_wr = 1'b1; div_sel = 1'b0; div_val = 4'd1;
    step();
    div_wr = 1'b0;
    check("wr_edge_tick", 32'(tick), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      step();
      check("retune_tick", 32'(tick),
            32'({((j - 1) % 4 == 0), (j % 2 == 1)}));
      check("retune_clk", 32'(clk_out),
            32'({(((j + 3) / 4) % 2 == 1), (((j + 1) / 2) % 2 == 1)}));
    end

    // Channels are now out of phase; sync realigns them.
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick", 32'(tick), 32'd0);
    check("sync_clk", 32'(clk_out), 32'd0);
    for (int s = 0; s < 4; s++) begin
      step();
      check("post_sync_tick", 32'(tick), 32'(tk_tab[s]));
      check("post_sync_clk", 32'(clk_out), 32'(ck_tab[s]));
    end

    // Divisor 0 written together with sync, channel 0 in pulse mode.
    div_wr = 1'b1; div_sel = 1'b0; div_val = 4'd0; sync = 1'b1; mode = 2'b01;
    step();
    div_wr = 1'b0; sync = 1'b0;
    check("wrsync_tick", 32'(tick), 32'd0);
    check("wrsync_clk", 32'(clk_out), 32'd0);
    for (int p = 1; p <= 5; p++) begin
      step();
      check("div0_pulse_tick", 32'(tick[0]), 32'd1);
      check("div0_pulse_clk", 32'(clk_out[0]), 32'd1);
    end
    mode = 2'b00;
    for (int m = 1; m <= 4; m++) begin
      step();
      check("div0_tog_tick", 32'(tick[0]), 32'd1);
      check("div0_tog_clk", 32'(clk_out[0]), (m % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Disable channel 1, retune it while idle, then re-enable.
    en = 2'b01;
    div_wr = 1'b1; div_sel = 1'b1; div_val = 4'd1;
    step();
    div_wr = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (d > 0) step();
      check("dis_tick", 32'(tick[1]), 32'd0);
      check("dis_clk", 32'(clk_out[1]), 32'd0);
    end
    en = 2'b11;
    for (int r = 1; r <= 4; r++) begin
      step();
      check("reen_tick", 32'(tick[1]), (r % 2 == 0) ? 32'd1 : 32'd0);
      check("reen_clk", 32'(clk_out[1]), (r == 2 || r == 3) ? 32'd1 : 32'd0);
    end

    // Leave a pending divisor on channel 1, then reset asynchronously mid-cycle.
    div_wr = 1'b1; div_sel = 1'b1; div_val = 4'd7;
    step();
    div_wr = 1'b0;
    check("pre_rst_tick0", 32'(tick[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_clk", 32'(clk_out), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("post_rst_tick", 32'(tick), (k % 4 == 0) ? 32'd3 : 32'd0);
      check("post_rst_clk", 32'(clk_out), (k >= 4 && k < 8) ? 32'd3 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
